// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields plus an immediate into an
// instruction word, range-checks the immediate and buffers {word,err} in a FIFO.
module inst_encoder #(
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      fmt,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [31:0]     imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic            out_err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_LOAD   = 3'd0;
  localparam logic [2:0] FMT_STORE  = 3'd1;
  localparam logic [2:0] FMT_OPIMM  = 3'd2;
  localparam logic [2:0] FMT_BRANCH = 3'd3;
  localparam logic [2:0] FMT_LUI    = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] w_word;
  logic        w_err;
  logic        w_fits12;
  logic        w_fits13;

  // A signed value fits N bits when every bit above N-2 equals the sign bit.
  assign w_fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_fits13 = (&imm[31:12]) | ~(|imm[31:12]);

  always_comb begin
    w_word = NOP_WORD;
    w_err  = 1'b1;
    case (fmt)
      FMT_LOAD: begin
        w_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        w_err  = ~w_fits12;
      end
      FMT_OPIMM: begin
        w_word = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
        w_err  = ~w_fits12;
      end
      FMT_STORE: begin
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        w_err  = ~w_fits12;
      end
      FMT_BRANCH: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        w_err  = ~w_fits13 | imm[0];
      end
      FMT_LUI: begin
        w_word = {imm[31:12], rd, OP_LUI};
        w_err  = |imm[11:0];
      end
      default: begin
        w_word = NOP_WORD;
        w_err  = 1'b1;
      end
    endcase
  end

  logic [31:0]   r_mem_inst [DEPTH];
  logic          r_mem_err  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hold_inst;
  logic          r_hold_err;
  logic [ERRW-1:0] r_err_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // No bypass: a full FIFO refuses input even while it is being popped.
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_err[i]  <= 1'b0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_inst[r_wptr] <= w_word;
        r_mem_err[r_wptr]  <= w_err;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // The hold registers shadow the visible head so the outputs keep their last
  // value once the FIFO drains, rather than exposing a stale slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_inst <= '0;
      r_hold_err  <= 1'b0;
    end else begin
      r_hold_inst <= out_inst;
      r_hold_err  <= out_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err && (r_err_cnt != {ERRW{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_inst  = w_empty ? r_hold_inst : r_mem_inst[r_rptr];
  assign out_err   = w_empty ? r_hold_err  : r_mem_err[r_rptr];
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: a reference encoder fills a scoreboard queue on every
// accepted request; the scenario tasks pop and compare as words leave the DUT.
module tb_inst_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct packed {
    req_t        r;
    logic        has_word;
    logic [31:0] word;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;
  req_t        drv = '0;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic [7:0] exp_err_cnt = 8'd0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(2), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(drv.fmt), .rd(drv.rd), .rs1(drv.rs1), .rs2(drv.rs2),
    .funct3(drv.f3), .imm(drv.imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  function automatic exp_t ref_enc(req_t r);
    exp_t   e;
    longint si;
    si = longint'($signed(r.imm));
    e.inst = 32'h13;
    e.err  = 1'b1;
    case (r.fmt)
      3'd0, 3'd2: begin
        e.inst = {r.imm[11:0], r.rs1, r.f3, r.rd, (r.fmt == 3'd0) ? 7'h03 : 7'h13};
        e.err  = (si < -2048) || (si > 2047);
      end
      3'd1: begin
        e.inst = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], 7'h23};
        e.err  = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        e.inst = 32'h63;
        e.inst[31]    = r.imm[12];
        e.inst[30:25] = r.imm[10:5];
        e.inst[24:20] = r.rs2;
        e.inst[19:15] = r.rs1;
        e.inst[14:12] = r.f3;
        e.inst[11:8]  = r.imm[4:1];
        e.inst[7]     = r.imm[11];
        e.err  = (si < -4096) || (si > 4094) || (si % 2 != 0);
      end
      3'd4: begin
        e.inst = (r.imm & 32'hFFFF_F000) | {20'd0, r.rd, 7'h37};
        e.err  = (r.imm % 4096) != 0;
      end
      default: begin
        e.inst = 32'h13;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      e = ref_enc(drv);
      q.push_back(e);
      if (e.err && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    end
  end

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%08h exp=00000000", out_inst); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_encode_vectors();
    vec_t tbl[$];
    tbl.push_back('{'{3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC}, 1'b1, 32'hFFC12283, 1'b0});
    tbl.push_back('{'{3'd1, 5'd0, 5'd2, 5'd6, 3'd2, 32'd8},        1'b1, 32'h00612423, 1'b0});
    tbl.push_back('{'{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8}, 1'b1, 32'hFE208CE3, 1'b0});
    tbl.push_back('{'{3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345000}, 1'b1, 32'h12345537, 1'b0});
    tbl.push_back('{'{3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345001}, 1'b1, 32'h12345537, 1'b1});
    tbl.push_back('{'{3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048},     1'b1, 32'h80000093, 1'b1});
    tbl.push_back('{'{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6},        1'b1, 32'h00000363, 1'b0});
    tbl.push_back('{'{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7},        1'b1, 32'h00000363, 1'b1});
    tbl.push_back('{'{3'd6, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0},        1'b1, 32'h00000013, 1'b1});
    tbl.push_back('{'{3'd2, 5'd7, 5'd9, 5'd0, 3'd4, 32'd2047},     1'b0, 32'h0, 1'b0});
    tbl.push_back('{'{3'd2, 5'd7, 5'd9, 5'd0, 3'd4, 32'hFFFF_F800}, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{'{3'd0, 5'd7, 5'd9, 5'd0, 3'd4, 32'hFFFF_F7FF}, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{'{3'd1, 5'd0, 5'd9, 5'd3, 3'd1, 32'hFFFF_F800}, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{'{3'd3, 5'd0, 5'd9, 5'd3, 3'd1, 32'd4094},     1'b0, 32'h0, 1'b0});
    tbl.push_back('{'{3'd3, 5'd0, 5'd9, 5'd3, 3'd1, 32'hFFFF_F000}, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{'{3'd3, 5'd0, 5'd9, 5'd3, 3'd1, 32'd4096},     1'b0, 32'h0, 1'b1});
    tbl.push_back('{'{3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0},        1'b0, 32'h0, 1'b1});
    foreach (tbl[i]) begin
      exp_t e;
      @(negedge clk);
      drv = tbl[i].r;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || q.size() != 1) begin
        failures++; $display("FAIL vec%0d_latency out_valid=%0b queued=%0d exp=1", i, out_valid, q.size());
        q.delete();
        continue;
      end
      e = q[0];
      checks++; if (out_inst !== e.inst || out_err !== e.err) begin
        failures++; $display("FAIL vec%0d_model got=%08h/%0b exp=%08h/%0b", i, out_inst, out_err, e.inst, e.err);
      end
      checks++; if (out_err !== tbl[i].err) begin
        failures++; $display("FAIL vec%0d_err got=%0b exp=%0b", i, out_err, tbl[i].err);
      end
      if (tbl[i].has_word) begin
        checks++; if (out_inst !== tbl[i].word) begin
          failures++; $display("FAIL vec%0d_word got=%08h exp=%08h", i, out_inst, tbl[i].word);
        end
      end
      out_ready = 1'b1;
      void'(q.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_inst !== e.inst || out_err !== e.err) begin
        failures++; $display("FAIL vec%0d_hold valid=%0b got=%08h/%0b exp=0 %08h/%0b", i, out_valid, out_inst, out_err, e.inst, e.err);
      end
    end
    checks++; if (err_cnt !== exp_err_cnt) begin
      failures++; $display("FAIL vec_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    req_t reqs[3];
    int   sent = 0;
    int   npop = 0;
    logic [31:0] head;
    reqs[0] = '{3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'd100};
    reqs[1] = '{3'd1, 5'd0, 5'd3, 5'd4, 3'd1, 32'hFFFF_FF00};
    reqs[2] = '{3'd3, 5'd0, 5'd5, 5'd6, 3'd5, 32'd64};
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv = reqs[k];
      in_valid = 1'b1;
    end
    @(negedge clk);
    drv = reqs[2];
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_in_ready got=%0b exp=0", in_ready); end
    head = out_inst;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || q.size() != 2) begin
      failures++; $display("FAIL b2b_stall in_ready=%0b queued=%0d exp=0/2", in_ready, q.size());
    end
    checks++; if (q.size() == 0 || out_inst !== head || out_inst !== q[0].inst) begin
      failures++; $display("FAIL b2b_stable got=%08h exp=%08h", out_inst, head);
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass in_ready=%0b exp=0", in_ready); end
    for (int c = 0; c < 20 && npop < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (sent) in_valid = 1'b0;
      if (out_valid) begin
        checks++; if (q.size() == 0 || out_inst !== q[0].inst || out_err !== q[0].err) begin
          failures++; $display("FAIL b2b_order pop%0d got=%08h/%0b", npop, out_inst, out_err);
        end
        if (q.size() != 0) void'(q.pop_front());
        npop++;
      end
      if (in_valid && in_ready) sent = 1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (npop != 3 || q.size() != 0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain pops=%0d queued=%0d exp=3/0", npop, q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0};
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_cnt !== exp_err_cnt) begin
      failures++; $display("FAIL midop_pre valid=%0b ready=%0b cnt=%0d exp=1/0/%0d", out_valid, in_ready, err_cnt, exp_err_cnt);
    end
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_err_cnt = 8'd0;
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
      failures++; $display("FAIL midop_reset valid=%0b cnt=%0d exp=0/0", out_valid, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midop_release ready=%0b valid=%0b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_err_saturation();
    int sent = 0;
    int npop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && (sent < 300 || q.size() != 0 || out_valid); c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++; if (q.size() == 0 || out_inst !== q[0].inst || out_err !== q[0].err) begin
          failures++; $display("FAIL sat_stream pop%0d got=%08h/%0b", npop, out_inst, out_err);
        end
        if (q.size() != 0) void'(q.pop_front());
        npop++;
      end
      in_valid = (sent < 300);
      if ($urandom_range(1) == 0) drv = '{3'($urandom_range(7, 5)), 5'd1, 5'd2, 5'd3, 3'd0, 32'd0};
      else drv = '{3'd4, 5'($urandom), 5'd0, 5'd0, 3'd0, $urandom | 32'h1};
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (sent != 300 || npop != 300) begin
      failures++; $display("FAIL sat_count sent=%0d pops=%0d exp=300/300", sent, npop);
    end
    checks++; if (err_cnt !== exp_err_cnt || err_cnt !== 8'd255) begin
      failures++; $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode_vectors();
    test_back_to_back();
    test_reset_midop();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
